keypad_scanner: RTL

- Scans a 4x4 hex key matrix and debounces it.
- Emits each accepted key press as a 4-bit code with a one-cycle `enable` strobe.
- This is the producer side of the key interface: its `key`/`key_valid` outputs drive the calculator's `in`/`enable` inputs directly.
- Handles column drive, row sampling, multi-key rejection, press debounce and release re-arming. Exactly one strobe is issued per physical press.

---
 rtl/keypad_scanner.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column drive, synchronized row sampling, per-frame
// single/multi-key classification and a press/release debouncer with a one-cycle strobe.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key,
    output logic       key_valid
);

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        HELD,
        RELEASE
    } scanState;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  DEB_TARGET = 8'(DEBOUNCE);

    logic [3:0]  rowMeta;
    logic [3:0]  rowSync;
    logic [15:0] divCount;
    logic [1:0]  colIdx;
    logic [1:0]  frameHits;
    logic [3:0]  frameCode;

    scanState    state;
    scanState    stateNext;
    logic [7:0]  cnt;
    logic [7:0]  cntNext;
    logic [3:0]  cand;
    logic [3:0]  candNext;
    logic [3:0]  keyNext;
    logic        keyValidNext;

    logic        sampleTick;
    logic        frameEnd;
    logic [3:0]  closed;
    logic [2:0]  colHits;
    logic [1:0]  colRow;
    logic [3:0]  colCode;
    logic [1:0]  hitsTotal;
    logic [3:0]  codeTotal;
    logic        resultNone;
    logic        resultSingle;
    logic [7:0]  cntInc;

    function automatic logic [3:0] codeOf(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // Column drive is decoded from the registered column index, so it is glitch-free per dwell.
    assign col = ~(4'b0001 << colIdx);

    assign sampleTick = (divCount == DIV_LAST);
    assign frameEnd   = sampleTick && (colIdx == 2'd3);
    assign closed     = ~rowSync;
    assign colHits    = {2'b00, closed[0]} + {2'b00, closed[1]}
                      + {2'b00, closed[2]} + {2'b00, closed[3]};
    assign colCode    = codeOf(colRow, colIdx);
    assign cntInc     = cnt + 8'd1;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        colRow = 2'd3;
        if (closed[0]) begin
            colRow = 2'd0;
        end else if (closed[1]) begin
            colRow = 2'd1;
        end else if (closed[2]) begin
            colRow = 2'd2;
        end
    end

    // Frame accumulator folded with the current column: 0 = none, 1 = single, 2 = multi.
    always_comb begin
        hitsTotal = frameHits;
        codeTotal = frameCode;
        if (sampleTick) begin
            if (colHits >= 3'd2) begin
                hitsTotal = 2'd2;
            end else if (colHits == 3'd1) begin
                if (frameHits == 2'd0) begin
                    hitsTotal = 2'd1;
                    codeTotal = colCode;
                end else begin
                    hitsTotal = 2'd2;
                end
            end
        end
    end

    assign resultNone   = (hitsTotal == 2'd0);
    assign resultSingle = (hitsTotal == 2'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rowMeta   <= 4'hF;
            rowSync   <= 4'hF;
            divCount  <= 16'd0;
            colIdx    <= 2'd0;
            frameHits <= 2'd0;
            frameCode <= 4'h0;
        end else begin
            rowMeta <= row;
            rowSync <= rowMeta;
            if (sampleTick) begin
                divCount <= 16'd0;
                colIdx   <= colIdx + 2'd1;
            end else begin
                divCount <= divCount + 16'd1;
            end
            if (frameEnd) begin
                frameHits <= 2'd0;
                frameCode <= 4'h0;
            end else if (sampleTick) begin
                frameHits <= hitsTotal;
                frameCode <= codeTotal;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            cand      <= 4'h0;
            key       <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            cand      <= candNext;
            key       <= keyNext;
            key_valid <= keyValidNext;
        end
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        candNext     = cand;
        keyNext      = key;
        keyValidNext = 1'b0;
        if (frameEnd) begin
            unique case (state)
                IDLE: begin
                    if (resultSingle) begin
                        candNext = codeTotal;
                        cntNext  = 8'd1;
                        if (DEB_TARGET == 8'd1) begin
                            keyNext      = codeTotal;
                            keyValidNext = 1'b1;
                            stateNext    = HELD;
                        end else begin
                            stateNext = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (resultSingle && (codeTotal == cand)) begin
                        cntNext = cntInc;
                        if (cntInc == DEB_TARGET) begin
                            keyNext      = cand;
                            keyValidNext = 1'b1;
                            stateNext    = HELD;
                        end
                    end else if (resultSingle) begin
                        candNext = codeTotal;
                        cntNext  = 8'd1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
                HELD: begin
                    // A different key without an intervening release never re-arms.
                    if (resultNone) begin
                        cntNext   = 8'd1;
                        stateNext = (DEB_TARGET == 8'd1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (resultNone) begin
                        cntNext = cntInc;
                        if (cntInc == DEB_TARGET) begin
                            stateNext = IDLE;
                        end
                    end else begin
                        stateNext = HELD;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

endmodule
